// File: rtl/osc_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state codes,
// requester indices and the one-byte holding register payload.
package osc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_TX = 2'd2,
    LOCKED  = 2'd3
  } arb_state_t;

  localparam int NUM_REQ          = 2;
  localparam int REQ_SAMPLE       = 0;
  localparam int REQ_CMD          = 1;
  localparam int DEF_TX_TIMEOUT   = 4096;
  localparam int DEF_LOCK_TIMEOUT = 1024;
  localparam int DEF_TMR_W        = 13;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } hold_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-byte holding register for a requester. A strobe is accepted when empty
// or when the current byte is being released in the same cycle.
module tx_hold_reg
  import osc_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_RESET,
  input  logic  en,
  input  hold_t wr,
  input  logic  rel,
  output logic  full,
  output hold_t rd,
  output logic  overrun
);

  logic cap;
  assign cap = en && (!full || rel);

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      full    <= 1'b0;
      rd      <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= en && !cap;
      if (cap) begin
        full <= 1'b1;
        rd   <= wr;
      end else if (rel) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between two byte-stream requesters. Ownership is granted
// per packet so multi-byte records from one requester are never interleaved.
module uart_tx_arbiter
  import osc_pkg::*;
#(
  parameter int RR_MODE      = 1,
  parameter int TX_TIMEOUT   = DEF_TX_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int TMR_W        = DEF_TMR_W
) (
  input  logic       i_clk,
  input  logic       i_RESET,
  input  logic       i_req0_en,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_last,
  output logic       o_req0_done,
  output logic       o_req0_busy,
  input  logic       i_req1_en,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req1_done,
  output logic       o_req1_busy,
  output logic       o_tx_en,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  output logic [1:0] o_grant,
  output logic       o_overrun,
  output logic       o_tx_timeout,
  output logic [1:0] o_state
);

  localparam logic [TMR_W-1:0] TX_LAST = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LK_LAST = TMR_W'(LOCK_TIMEOUT - 1);

  logic  [NUM_REQ-1:0] req_en, full, rel, ovr;
  hold_t [NUM_REQ-1:0] wr, rd;

  assign req_en          = {i_req1_en, i_req0_en};
  assign wr[REQ_SAMPLE]  = '{data: i_req0_data, last: i_req0_last};
  assign wr[REQ_CMD]     = '{data: i_req1_data, last: i_req1_last};

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_hold
    tx_hold_reg u_hold (
      .i_clk   (i_clk),
      .i_RESET (i_RESET),
      .en      (req_en[n]),
      .wr      (wr[n]),
      .rel     (rel[n]),
      .full    (full[n]),
      .rd      (rd[n]),
      .overrun (ovr[n])
    );
  end

  arb_state_t         state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [1:0]         grant_nx, done_q, done_nx;
  logic [7:0]         tx_data_nx;
  logic               tx_en_nx, tmo_nx;
  logic               ptr, ptr_nx;  // requester preferred when both are waiting
  logic               own, win;

  assign own = o_grant[1];
  assign win = (RR_MODE != 0 && (&full)) ? ptr : !full[REQ_SAMPLE];

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    grant_nx   = o_grant;
    tx_en_nx   = 1'b0;
    tx_data_nx = o_tx_data;
    done_nx    = '0;
    tmo_nx     = 1'b0;
    ptr_nx     = ptr;
    rel        = '0;
    case (state)
      IDLE: begin
        if (|full) begin
          grant_nx = onehot(win);
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_data_nx = rd[own].data;
        tx_en_nx   = 1'b1;
        timer_nx   = '0;
        state_nx   = WAIT_TX;
      end
      WAIT_TX: begin
        timer_nx = timer + 1'b1;
        // done takes precedence over an expiring timer on the same cycle
        if (i_tx_done) begin
          rel[own]     = 1'b1;
          done_nx[own] = 1'b1;
          timer_nx     = '0;
          if (rd[own].last) begin
            ptr_nx   = !own;
            grant_nx = '0;
            state_nx = IDLE;
          end else begin
            state_nx = LOCKED;
          end
        end else if (timer == TX_LAST) begin
          rel[own] = 1'b1;
          tmo_nx   = 1'b1;
          grant_nx = '0;
          timer_nx = '0;
          state_nx = IDLE;
        end
      end
      LOCKED: begin
        if (full[own]) begin
          timer_nx = '0;
          state_nx = LAUNCH;
        end else if (timer == LK_LAST) begin
          ptr_nx   = !own;
          grant_nx = '0;
          timer_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      state        <= IDLE;
      timer        <= '0;
      o_grant      <= '0;
      o_tx_en      <= 1'b0;
      o_tx_data    <= '0;
      done_q       <= '0;
      o_tx_timeout <= 1'b0;
      ptr          <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      o_grant      <= grant_nx;
      o_tx_en      <= tx_en_nx;
      o_tx_data    <= tx_data_nx;
      done_q       <= done_nx;
      o_tx_timeout <= tmo_nx;
      ptr          <= ptr_nx;
    end
  end

  assign o_req0_done = done_q[REQ_SAMPLE];
  assign o_req1_done = done_q[REQ_CMD];
  assign o_req0_busy = full[REQ_SAMPLE];
  assign o_req1_busy = full[REQ_CMD];
  assign o_overrun   = |ovr;
  assign o_state     = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a round-robin instance with short timeouts and a
// fixed-priority instance with a slower UART model, each scoreboarded.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en0, l0, en1, l1, tx_done;
  logic [7:0] d0, d1, tx_data;
  logic       done0, done1, busy0, busy1, tx_en, ovr, tmo;
  logic [1:0] grant, state;

  logic       f_en0, f_l0, f_en1, f_l1, f_tx_done;
  logic [7:0] f_d0, f_d1, f_tx_data;
  logic       f_done0, f_done1, f_busy0, f_busy1, f_tx_en, f_ovr, f_tmo;
  logic [1:0] f_grant, f_state;

  uart_tx_arbiter #(.RR_MODE(1), .TX_TIMEOUT(16), .LOCK_TIMEOUT(8), .TMR_W(13)) dut (
    .i_clk(clk), .i_RESET(rst),
    .i_req0_en(en0), .i_req0_data(d0), .i_req0_last(l0), .o_req0_done(done0), .o_req0_busy(busy0),
    .i_req1_en(en1), .i_req1_data(d1), .i_req1_last(l1), .o_req1_done(done1), .o_req1_busy(busy1),
    .o_tx_en(tx_en), .o_tx_data(tx_data), .i_tx_done(tx_done), .o_grant(grant),
    .o_overrun(ovr), .o_tx_timeout(tmo), .o_state(state));

  uart_tx_arbiter #(.RR_MODE(0), .TX_TIMEOUT(64), .LOCK_TIMEOUT(32), .TMR_W(13)) fdut (
    .i_clk(clk), .i_RESET(rst),
    .i_req0_en(f_en0), .i_req0_data(f_d0), .i_req0_last(f_l0), .o_req0_done(f_done0), .o_req0_busy(f_busy0),
    .i_req1_en(f_en1), .i_req1_data(f_d1), .i_req1_last(f_l1), .o_req1_done(f_done1), .o_req1_busy(f_busy1),
    .o_tx_en(f_tx_en), .o_tx_data(f_tx_data), .i_tx_done(f_tx_done), .o_grant(f_grant),
    .o_overrun(f_ovr), .o_tx_timeout(f_tmo), .o_state(f_state));

  int chk = 0, pass = 0;
  logic [9:0] obs_q[$], f_obs[$];   // {grant, data} per o_tx_en
  logic [7:0] exp0[$], exp1[$];
  int nd0 = 0, nd1 = 0, novr = 0, ntmo = 0, f_nd0 = 0;
  int ucnt = 0, f_ucnt = 0;
  bit uart_on = 1'b1;
  int man_req = 0;

  // UART models and event recorder; they act just after each rising edge
  initial begin
    int man_seen;
    man_seen  = 0;
    tx_done   = 1'b0;
    f_tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      tx_done   = (man_req != man_seen);
      man_seen  = man_req;
      f_tx_done = 1'b0;
      if (rst) begin
        ucnt   = 0;
        f_ucnt = 0;
      end else begin
        if (tx_en) begin
          obs_q.push_back({grant, tx_data});
          if (uart_on) ucnt = 10;
        end else if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0) tx_done = 1'b1;
        end
        if (f_tx_en) begin
          f_obs.push_back({f_grant, f_tx_data});
          f_ucnt = 20;
        end else if (f_ucnt > 0) begin
          f_ucnt--;
          if (f_ucnt == 0) f_tx_done = 1'b1;
        end
      end
      if (done0) nd0++;
      if (done1) nd1++;
      if (ovr) novr++;
      if (tmo) ntmo++;
      if (f_done0) f_nd0++;
    end
  end

  task automatic drive(input bit f, input bit e0, input logic [7:0] v0, input bit t0,
                       input bit e1, input logic [7:0] v1, input bit t1);
    if (f) begin
      f_en0 = e0; f_d0 = v0; f_l0 = t0; f_en1 = e1; f_d1 = v1; f_l1 = t1;
    end else begin
      en0 = e0; d0 = v0; l0 = t0; en1 = e1; d1 = v1; l1 = t1;
      if (e0) exp0.push_back(v0);
      if (e1) exp1.push_back(v1);
    end
    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0; f_en0 = 1'b0; f_en1 = 1'b0;
  endtask

  task automatic wait_idle(input bit f);
    for (int i = 0; i < 600; i++) begin
      if (!f && state == 2'd0 && grant == 2'b00 && !busy0 && !busy1 && ucnt == 0) break;
      if (f && f_state == 2'd0 && f_grant == 2'b00 && !f_busy0 && !f_busy1 && f_ucnt == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done0(input bit f);
    for (int i = 0; i < 200; i++) begin
      if ((!f && done0) || (f && f_done0)) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    chk++; if ({done0, done1, busy0, busy1, tx_en, ovr, tmo} !== 7'b0) $display("FAIL reset_flags got %b want 0", {done0, done1, busy0, busy1, tx_en, ovr, tmo}); else pass++;
    chk++; if ({tx_data, grant, state} !== 12'h0) $display("FAIL reset_bus got %h want 0", {tx_data, grant, state}); else pass++;
    chk++; if ({f_tx_en, f_grant, f_state, f_busy0, f_busy1} !== 7'b0) $display("FAIL reset_fixed got %b want 0", {f_tx_en, f_grant, f_state, f_busy0, f_busy1}); else pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_packet;
    int b, n;
    b = f_nd0;
    f_obs.delete();
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    chk++; if ({f_busy0, f_grant, f_tx_en} !== 4'b1_00_0) $display("FAIL lat_busy got %b want 1000", {f_busy0, f_grant, f_tx_en}); else pass++;
    @(negedge clk);
    chk++; if ({f_busy0, f_grant, f_tx_en} !== 4'b1_01_0) $display("FAIL lat_grant got %b want 1010", {f_busy0, f_grant, f_tx_en}); else pass++;
    @(negedge clk);
    chk++; if ({f_tx_en, f_tx_data} !== 9'h1A5) $display("FAIL lat_tx_en got %h want 1a5", {f_tx_en, f_tx_data}); else pass++;
    n = 0;
    while (!f_done0 && n < 200) begin @(negedge clk); n++; end
    chk++; if (n !== 21) $display("FAIL done_latency got %0d want 21", n); else pass++;
    chk++; if (f_grant !== 2'b01) $display("FAIL single_grant_mid got %b want 01", f_grant); else pass++;
    drive(1'b1, 1'b1, 8'h0B, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done0(1'b1);
    chk++; if (f_grant !== 2'b00) $display("FAIL single_grant_end got %b want 00", f_grant); else pass++;
    wait_idle(1'b1);
    chk++; if (f_obs.size() !== 2) $display("FAIL single_ntx got %0d want 2", f_obs.size()); else pass++;
    chk++; if (f_obs[0] !== {2'b01, 8'hA5} || f_obs[1] !== {2'b01, 8'h0B}) $display("FAIL single_data got %h %h want 1a5 10b", f_obs[0], f_obs[1]); else pass++;
    chk++; if (f_nd0 - b !== 2) $display("FAIL single_done got %0d want 2", f_nd0 - b); else pass++;
  endtask

  task automatic check_stream(input string name, input logic [1:0] gx [4]);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      chk++; if (obs_q[i][9:8] !== gx[i]) $display("FAIL %s_grant%0d got %b want %b", name, i, obs_q[i][9:8], gx[i]); else pass++;
      if (gx[i] == 2'b01) e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
      else                e = (exp1.size() > 0) ? exp1.pop_front() : 8'hxx;
      chk++; if (obs_q[i][7:0] !== e) $display("FAIL %s_data%0d got %h want %h", name, i, obs_q[i][7:0], e); else pass++;
    end
  endtask

  task automatic test_packet_lock;
    int b;
    logic [1:0] gx [4];
    gx = '{2'b01, 2'b01, 2'b01, 2'b10};
    b = nd1;
    obs_q.delete();
    drive(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 50 && obs_q.size() < 1; i++) @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1);
    for (int k = 2; k <= 3; k++) begin
      wait_done0(1'b0);
      drive(1'b0, 1'b1, 8'hC0 + 8'(k), k == 3, 1'b0, 8'h00, 1'b0);
    end
    wait_idle(1'b0);
    chk++; if (obs_q.size() !== 4) $display("FAIL lock_ntx got %0d want 4", obs_q.size()); else pass++;
    check_stream("lock", gx);
    chk++; if (nd1 - b !== 1) $display("FAIL lock_req1_done got %0d want 1", nd1 - b); else pass++;
  endtask

  task automatic test_round_robin;
    int s0, s1;
    bit e0, e1;
    logic [1:0] gx [4];
    gx = '{2'b01, 2'b10, 2'b01, 2'b10};
    obs_q.delete();
    s0 = 1; s1 = 1;
    drive(1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1);
    // refill on the tx_done cycle so both registers are full at each decision
    for (int i = 0; i < 600 && obs_q.size() < 4; i++) begin
      e0 = tx_done && grant == 2'b01 && s0 < 2;
      e1 = tx_done && grant == 2'b10 && s1 < 2;
      if (e0 || e1) begin
        drive(1'b0, e0, 8'h10 + 8'(s0), 1'b1, e1, 8'h20 + 8'(s1), 1'b1);
        s0 += int'(e0); s1 += int'(e1);
      end else @(negedge clk);
    end
    wait_idle(1'b0);
    chk++; if (obs_q.size() !== 4) $display("FAIL rr_ntx got %0d want 4", obs_q.size()); else pass++;
    check_stream("rr", gx);
  endtask

  task automatic test_fixed_priority;
    int s0;
    logic [9:0] want [4];
    want = '{{2'b01, 8'h40}, {2'b01, 8'h41}, {2'b01, 8'h42}, {2'b10, 8'h50}};
    f_obs.delete();
    s0 = 1;
    drive(1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 8'h50, 1'b1);
    for (int i = 0; i < 2000 && f_obs.size() < 4; i++) begin
      if (f_tx_done && f_grant == 2'b01 && s0 < 3) begin
        drive(1'b1, 1'b1, 8'h40 + 8'(s0), 1'b1, 1'b0, 8'h00, 1'b0);
        s0++;
      end else @(negedge clk);
    end
    wait_idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk++; if (f_obs[i] !== want[i]) $display("FAIL fixed_tx%0d got %h want %h", i, f_obs[i], want[i]); else pass++;
    end
  endtask

  task automatic test_overrun;
    int b;
    b = novr;
    obs_q.delete();
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
    exp0.delete(exp0.size() - 1);
    wait_done0(1'b0);
    drive(1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_idle(1'b0);
    chk++; if (novr - b !== 1) $display("FAIL overrun_count got %0d want 1", novr - b); else pass++;
    chk++; if (obs_q.size() !== 2) $display("FAIL overrun_ntx got %0d want 2", obs_q.size()); else pass++;
    chk++; if (obs_q[0] !== {2'b01, exp0[0]} || obs_q[1] !== {2'b01, exp0[1]}) $display("FAIL overrun_data got %h %h want 111 133", obs_q[0], obs_q[1]); else pass++;
    exp0.delete();
  endtask

  task automatic test_tx_timeout;
    int bd, bt, n;
    bd = nd0; bt = ntmo;
    uart_on = 1'b0;
    obs_q.delete();
    drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 50 && obs_q.size() < 1; i++) @(negedge clk);
    n = 0;
    while (!tmo && n < 100) begin @(negedge clk); n++; end
    chk++; if (n !== 16) $display("FAIL tmo_latency got %0d want 16", n); else pass++;
    chk++; if ({busy0, grant, state} !== 5'b0) $display("FAIL tmo_release got %b want 0", {busy0, grant, state}); else pass++;
    repeat (3) @(negedge clk);
    chk++; if (ntmo - bt !== 1) $display("FAIL tmo_count got %0d want 1", ntmo - bt); else pass++;
    chk++; if (nd0 - bd !== 0) $display("FAIL tmo_no_done got %0d want 0", nd0 - bd); else pass++;
    chk++; if (obs_q.size() !== 1 || obs_q[0] !== {2'b01, 8'h77}) $display("FAIL tmo_tx got %0d/%h want 1/177", obs_q.size(), obs_q[0]); else pass++;
    exp0.delete();
    uart_on = 1'b1;
  endtask

  task automatic test_lock_timeout;
    int n;
    obs_q.delete();
    drive(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_done0(1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1);
    n = 1;
    while (grant != 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk++; if (n !== 8) $display("FAIL lock_release got %0d want 8", n); else pass++;
    wait_idle(1'b0);
    chk++; if (obs_q.size() !== 2) $display("FAIL lockto_ntx got %0d want 2", obs_q.size()); else pass++;
    chk++; if (obs_q[0] !== {2'b01, 8'h81} || obs_q[1] !== {2'b10, 8'h99}) $display("FAIL lockto_data got %h %h want 181 299", obs_q[0], obs_q[1]); else pass++;
    exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset_mid;
    int bd;
    bd = nd0;
    uart_on = 1'b0;
    obs_q.delete();
    drive(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 50 && obs_q.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk++; if (state !== 2'd2) $display("FAIL rstmid_pre got %0d want 2", state); else pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk++; if ({done0, busy0, tx_en, tx_data, grant, ovr, tmo, state} !== 17'b0) $display("FAIL rstmid_outputs got %h want 0", {done0, busy0, tx_en, tx_data, grant, ovr, tmo, state}); else pass++;
    man_req++;
    repeat (5) @(negedge clk);
    chk++; if (nd0 - bd !== 0) $display("FAIL rstmid_done got %0d want 0", nd0 - bd); else pass++;
    chk++; if ({obs_q.size() == 1, state, grant, busy0} !== 6'b1_00_00_0) $display("FAIL rstmid_idle got %b want 100000", {obs_q.size() == 1, state, grant, busy0}); else pass++;
    exp0.delete();
    uart_on = 1'b1;
  endtask

  initial begin
    en0 = 0; d0 = 0; l0 = 0; en1 = 0; d1 = 0; l1 = 0;
    f_en0 = 0; f_d0 = 0; f_l0 = 0; f_en1 = 0; f_d1 = 0; f_l1 = 0;
    test_reset();
    test_single_packet();
    test_packet_lock();
    test_round_robin();
    test_fixed_priority();
    test_overrun();
    test_tx_timeout();
    test_lock_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
